// File: rtl/lcd1602_drive.sv
// lcd1602_drive: write-only HD44780 bus driver for the DE2 16x2 character panel.
// Powers up, runs the four-command init once, then rewrites both lines forever
// from a per-frame snapshot of the incoming character image.
module lcd1602_drive #(
  parameter int P_PWR   = 750000,
  parameter int P_SETUP = 4,
  parameter int P_EN    = 16,
  parameter int P_WAIT  = 2000,
  parameter int P_CLR   = 100000
) (
  input  logic         CLOCK_50,
  input  logic         rst_n,
  input  logic [199:0] data_in,
  input  logic         bl_in,
  output logic [7:0]   LCD_DATA,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_EN,
  output logic         LCD_ON,
  output logic         LCD_BLON,
  output logic         frame_done
);

  // One shared phase counter, wide enough for the longest timing parameter.
  localparam int MAX_A = (P_PWR > P_CLR) ? P_PWR : P_CLR;
  localparam int MAX_B = (P_WAIT > P_EN) ? P_WAIT : P_EN;
  localparam int MAX_C = (MAX_B > P_SETUP) ? MAX_B : P_SETUP;
  localparam int MAXP  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW    = $clog2(MAXP + 1);

  typedef enum logic [1:0] {T_PWR, T_INIT, T_FRAME} top_t;
  typedef enum logic [1:0] {W_SETUP, W_EN, W_HOLD} wr_t;

  top_t          top, top_n;
  wr_t           wst, wst_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] hold_last;
  logic [5:0]    idx, idx_n;
  logic [199:0]  snap;
  logic          load;
  logic          snap_cap;
  logic [8:0]    word_n;

  // {RS, byte} for write number i of the given top-level phase.
  function automatic logic [8:0] write_word(input top_t t, input logic [5:0] i,
                                            input logic [199:0] s);
    logic [4:0] k;
    logic [7:0] base;
    logic [8:0] w;
    k = 5'd0;
    w = {1'b1, 8'h20};
    if (t == T_INIT) begin
      case (i)
        6'd0:    w = {1'b0, 8'h38};
        6'd1:    w = {1'b0, 8'h0C};
        6'd2:    w = {1'b0, 8'h06};
        default: w = {1'b0, 8'h01};
      endcase
    end else if (i == 6'd0) begin
      w = {1'b0, 8'h80};
    end else if (i <= 6'd16) begin
      k = 5'(i - 6'd1);
      w = {1'b1, 8'h00};
    end else if (i == 6'd17) begin
      w = {1'b0, 8'hC0};
    end else if (i <= 6'd26) begin
      k = 5'(i - 6'd2);
      w = {1'b1, 8'h00};
    end
    base = {k, 3'b000};
    if (w[8] && ((t == T_FRAME) && (i != 6'd0) && (i != 6'd17) && (i <= 6'd26)))
      w = {1'b1, s[base +: 8]};
    return w;
  endfunction

  // The clear command needs the long settle time; everything else the normal one.
  assign hold_last  = ((top == T_INIT) && (idx == 6'd3)) ? CW'(P_CLR - 1) : CW'(P_WAIT - 1);
  assign snap_cap   = (top == T_FRAME) && (idx == 6'd0) && (wst == W_SETUP) && (cnt == '0);
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = (top != T_PWR) && (wst == W_EN);
  assign frame_done = (top == T_FRAME) && (wst == W_HOLD) && (idx == 6'd33) &&
                      (cnt == CW'(P_WAIT - 1));

  // Next-state logic for the top-level sequence and the per-write phase FSM.
  always_comb begin
    top_n = top;
    wst_n = wst;
    cnt_n = cnt + CW'(1);
    idx_n = idx;
    load  = 1'b0;
    case (top)
      T_PWR: begin
        if (cnt == CW'(P_PWR)) begin
          top_n = T_INIT;
          wst_n = W_SETUP;
          cnt_n = '0;
          idx_n = '0;
          load  = 1'b1;
        end
      end
      default: begin
        case (wst)
          W_SETUP: begin
            if (cnt == CW'(P_SETUP - 1)) begin
              wst_n = W_EN;
              cnt_n = '0;
            end
          end
          W_EN: begin
            if (cnt == CW'(P_EN - 1)) begin
              wst_n = W_HOLD;
              cnt_n = '0;
            end
          end
          default: begin
            if (cnt == hold_last) begin
              wst_n = W_SETUP;
              cnt_n = '0;
              load  = 1'b1;
              if (top == T_INIT) begin
                if (idx == 6'd3) begin
                  top_n = T_FRAME;
                  idx_n = '0;
                end else begin
                  idx_n = idx + 6'd1;
                end
              end else begin
                idx_n = (idx == 6'd33) ? 6'd0 : idx + 6'd1;
              end
            end
          end
        endcase
      end
    endcase
  end

  // Bus byte for the upcoming write, read from the snapshot already in place.
  assign word_n = write_word(top_n, idx_n, snap);

  // State, counters, snapshot and registered bus outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      top      <= T_PWR;
      wst      <= W_SETUP;
      cnt      <= '0;
      idx      <= '0;
      snap     <= {25{8'h20}};
      LCD_DATA <= 8'h00;
      LCD_RS   <= 1'b0;
      LCD_ON   <= 1'b0;
      LCD_BLON <= 1'b0;
    end else begin
      top      <= top_n;
      wst      <= wst_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      LCD_ON   <= 1'b1;
      LCD_BLON <= bl_in;
      if (snap_cap)
        snap <= data_in;
      if (load)
        {LCD_RS, LCD_DATA} <= word_n;
    end
  end

endmodule

// File: tb/tb_lcd1602_drive.sv
// Scoreboard bench for lcd1602_drive with short timing parameters.
module tb_lcd1602_drive;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [199:0] data_in;
  logic         bl_in;
  logic [7:0]   LCD_DATA;
  logic         LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, frame_done;

  lcd1602_drive #(
    .P_PWR(10), .P_SETUP(2), .P_EN(3), .P_WAIT(5), .P_CLR(20)
  ) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .data_in(data_in), .bl_in(bl_in),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rel = 0;
  int   last_rise = 0;
  int   fd_n = 0;
  int   fd_c1 = 0;
  int   fd_c2 = 0;
  logic en_prev = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_prev <= LCD_EN;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_done === 1'b1) begin
      if (fd_n == 0) fd_c1 = cyc;
      else if (fd_n == 1) fd_c2 = cyc;
      fd_n = fd_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass = n_pass + 1;
  endtask

  task automatic push(input logic rs, input logic [7:0] d, input int gap, input string tag);
    exp_t e;
    e.rs = rs; e.d = d; e.gap = gap; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, 0,  "init38");
    push(1'b0, 8'h0C, 10, "init0C");
    push(1'b0, 8'h06, 10, "init06");
    push(1'b0, 8'h01, 10, "init01");
  endtask

  task automatic push_frame(input logic [199:0] d, input int first_gap);
    push(1'b0, 8'h80, first_gap, "cmd80");
    for (int k = 0; k < 16; k++) push(1'b1, d[8*k +: 8], 10, $sformatf("l1c%0d", k));
    push(1'b0, 8'hC0, 10, "cmdC0");
    for (int k = 16; k < 25; k++) push(1'b1, d[8*k +: 8], 10, $sformatf("l2c%0d", k - 16));
    for (int k = 0; k < 7; k++) push(1'b1, 8'h20, 10, $sformatf("pad%0d", k));
  endtask

  // Wait for the next EN rise, pop the expected write and compare; optionally
  // follow the strobe to its fall to check width and data hold.
  task automatic expect_write(input bit measure);
    bit   ok;
    exp_t e;
    int   w;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (LCD_EN === 1'b1 && en_prev === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("en_rise_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_rs"}, {31'd0, LCD_RS}, {31'd0, e.rs});
    check({e.tag, "_data"}, {24'd0, LCD_DATA}, {24'd0, e.d});
    if (e.gap != 0) check({e.tag, "_gap"}, cyc - last_rise, e.gap);
    last_rise = cyc;
    if (measure) begin
      w = 1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (LCD_EN !== 1'b1) break;
        w = w + 1;
      end
      check({e.tag, "_en_width"}, w, 32'd3);
      check({e.tag, "_hold_data"}, {23'd0, LCD_RS, LCD_DATA}, {23'd0, e.rs, e.d});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    string txt;
    txt   = "2024/05/17 12:30Friday   ";
    rst_n = 1'b0;
    bl_in = 1'b1;
    for (int k = 0; k < 25; k++) data_in[8*k +: 8] = txt[k];

    repeat (5) @(negedge clk);
    check("rst_data", {24'd0, LCD_DATA}, 32'h00);
    check("rst_rs", {31'd0, LCD_RS}, 32'd0);
    check("rst_rw", {31'd0, LCD_RW}, 32'd0);
    check("rst_en", {31'd0, LCD_EN}, 32'd0);
    check("rst_on", {31'd0, LCD_ON}, 32'd0);
    check("rst_blon", {31'd0, LCD_BLON}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);

    push_init();
    push_frame(data_in, 25);
    rst_n = 1'b1;
    rel   = cyc;

    @(negedge clk);
    check("on_after_release", {31'd0, LCD_ON}, 32'd1);
    check("en_idle_pwr", {31'd0, LCD_EN}, 32'd0);
    check("blon_pwr_on", {31'd0, LCD_BLON}, 32'd1);
    bl_in = 1'b0;
    check("blon_pwr_latency", {31'd0, LCD_BLON}, 32'd1);
    @(negedge clk);
    check("blon_pwr_off", {31'd0, LCD_BLON}, 32'd0);

    expect_write(1'b1);
    check("startup_rise", last_rise - rel - 1, 32'd12);
    repeat (3) expect_write(1'b1);

    // Frame 1: change char 3 mid-frame; the snapshot must hide it until frame 2.
    repeat (3) expect_write(1'b1);
    data_in[31:24] = 8'h39;
    push_frame(data_in, 10);
    repeat (31) expect_write(1'b1);

    // Frame 2
    expect_write(1'b1);
    check("frame_done_count1", fd_n, 32'd1);
    check("frame_done_to_80", last_rise - fd_c1, 32'd3);
    push_frame(data_in, 10);
    expect_write(1'b1);
    bl_in = 1'b1;
    check("blon_frame_latency", {31'd0, LCD_BLON}, 32'd0);
    @(negedge clk);
    check("blon_frame_on", {31'd0, LCD_BLON}, 32'd1);
    repeat (32) expect_write(1'b1);

    // Frame 3, reset during EN of the 5th data write
    expect_write(1'b1);
    check("frame_done_count2", fd_n, 32'd2);
    check("frame_done_period", fd_c2 - fd_c1, 32'd340);
    repeat (4) expect_write(1'b1);
    expect_write(1'b0);
    check("en_high_before_reset", {31'd0, LCD_EN}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_en", {31'd0, LCD_EN}, 32'd0);
    check("midrst_on", {31'd0, LCD_ON}, 32'd0);
    check("midrst_blon", {31'd0, LCD_BLON}, 32'd0);
    check("midrst_data", {24'd0, LCD_DATA}, 32'h00);
    check("midrst_rs", {31'd0, LCD_RS}, 32'd0);
    repeat (2) @(negedge clk);
    sb.delete();
    push_init();
    rst_n = 1'b1;
    rel   = cyc;
    expect_write(1'b1);
    check("restart_rise", last_rise - rel - 1, 32'd12);
    repeat (3) expect_write(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
